// File: rtl/param_byte_gearbox.sv
// param_byte_gearbox: single-clock width gearbox. Accepts IN_BYTES-wide words
// with a per-byte valid mask and emits packed OUT_BYTES-wide words, MSB byte
// first, with no gaps between valid bytes. DEPTH input words are buffered.
// Optional feature macro: GB_FLUSH_EN (frame flush via rx_last/tx_last/tx_byte_cnt).
module param_byte_gearbox #(
    parameter int IN_BYTES  = 32,
    parameter int OUT_BYTES = 3,
    parameter int DEPTH     = 16
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic [IN_BYTES*8-1:0]      rx_data,
    input  logic [IN_BYTES-1:0]        rx_byte_valid,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [OUT_BYTES*8-1:0]     tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       err_overflow
`ifdef GB_FLUSH_EN
    ,
    input  logic                       rx_last,
    output logic                       tx_last,
    output logic [$clog2(OUT_BYTES):0] tx_byte_cnt
`endif
);
    localparam int ACC_BYTES = IN_BYTES + OUT_BYTES - 1;
    localparam int IN_W      = IN_BYTES * 8;
    localparam int OUT_W     = OUT_BYTES * 8;
    localparam int ACC_W     = ACC_BYTES * 8;
    localparam int LW        = $clog2(IN_BYTES + 1);
    localparam int CW        = $clog2(ACC_BYTES + 1);
    localparam int PW        = $clog2(DEPTH);

    logic [LW+IN_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW:0]        level_q, level_d;
    logic               err_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]      acc_cnt_q, acc_cnt_d;
    logic [OUT_W-1:0]   tx_data_q;
    logic               tx_valid_q;

    logic [LW-1:0]      wr_len, rd_len;
    logic [IN_W-1:0]    wr_data, rd_data;
    logic               in_run;
    logic               accept, push, pop, fire, load_ok, append_ok;
    logic [CW-1:0]      emit, cnt_after;
    logic [ACC_W-1:0]   acc_shift, acc_word;

`ifdef GB_FLUSH_EN
    logic               last_mem_q [DEPTH];
    logic               acc_last_q, acc_last_d;
    logic               tx_last_q;
    logic [$clog2(OUT_BYTES):0] tx_byte_cnt_q;
    logic               rd_last, flush_fire, empty_last, mark_direct, mark_prev;
`endif

    assign rx_ready     = level_q < (PW+1)'(DEPTH);
    assign accept       = rx_valid & rx_ready;
    assign push         = accept & (wr_len != '0);
    assign {rd_len, rd_data} = mem_q[rd_ptr_q];
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign fifo_level   = level_q;
    assign err_overflow = err_q;

    // Leading run of valid bytes from the MSB end; bytes outside the run are zeroed
    always_comb begin
        wr_len  = '0;
        wr_data = '0;
        in_run  = 1'b1;
        for (int unsigned i = 0; i < IN_BYTES; i++) begin
            if (in_run && rx_byte_valid[IN_BYTES-1-i]) begin
                wr_len = wr_len + LW'(1);
                wr_data[(IN_BYTES-1-i)*8 +: 8] = rx_data[(IN_BYTES-1-i)*8 +: 8];
            end else begin
                in_run = 1'b0;
            end
        end
    end

    // Output load decision, accumulator shift and append of the next buffered word
    always_comb begin
        load_ok = ~tx_valid_q | tx_ready;
        fire    = 1'b0;
        emit    = '0;
`ifdef GB_FLUSH_EN
        rd_last    = last_mem_q[rd_ptr_q];
        flush_fire = load_ok & acc_last_q & (acc_cnt_q <= CW'(OUT_BYTES));
        if (flush_fire) begin
            fire = 1'b1;
            emit = acc_cnt_q;
        end else if (load_ok && acc_cnt_q >= CW'(OUT_BYTES)) begin
            fire = 1'b1;
            emit = CW'(OUT_BYTES);
        end
        // next frame waits until the flush word has left the accumulator
        append_ok = ~acc_last_q | flush_fire;
`else
        if (load_ok && acc_cnt_q >= CW'(OUT_BYTES)) begin
            fire = 1'b1;
            emit = CW'(OUT_BYTES);
        end
        append_ok = 1'b1;
`endif
        cnt_after = acc_cnt_q - emit;
        pop       = (level_q != '0) & append_ok & (cnt_after < CW'(OUT_BYTES));
        acc_shift = acc_q << {emit, 3'b000};
        // the new word's first byte lands directly behind the bytes still held
        acc_word  = (ACC_W'(rd_data) << ((OUT_BYTES - 1) * 8)) >> {cnt_after, 3'b000};
        acc_d     = pop ? (acc_shift | acc_word) : acc_shift;
        acc_cnt_d = cnt_after + (pop ? CW'(rd_len) : '0);
        case ({push, pop})
            2'b10:   level_d = level_q + (PW+1)'(1);
            2'b01:   level_d = level_q - (PW+1)'(1);
            default: level_d = level_q;
        endcase
`ifdef GB_FLUSH_EN
        // an empty last word flushes through the newest buffered word, or the accumulator if none remains
        empty_last  = accept & (wr_len == '0) & rx_last;
        mark_direct = empty_last & ((level_q == '0) | ((level_q == (PW+1)'(1)) & pop));
        mark_prev   = empty_last & ~mark_direct;
        acc_last_d  = (acc_last_q & ~flush_fire) | (pop & rd_last) | mark_direct;
`endif
    end

    // Buffer storage (contents need no reset; level tracks validity)
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_len, wr_data};
        end
`ifdef GB_FLUSH_EN
        if (push) begin
            last_mem_q[wr_ptr_q] <= rx_last;
        end else if (mark_prev) begin
            last_mem_q[wr_ptr_q - PW'(1)] <= 1'b1;
        end
`endif
    end

    // Buffer pointers, level and sticky overflow flag
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
            if (rx_valid && !rx_ready) err_q <= 1'b1;
        end
    end

    // Byte accumulator
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            acc_cnt_q <= '0;
`ifdef GB_FLUSH_EN
            acc_last_q <= 1'b0;
`endif
        end else begin
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
`ifdef GB_FLUSH_EN
            acc_last_q <= acc_last_d;
`endif
        end
    end

    // Output register, held while the downstream stalls
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef GB_FLUSH_EN
            tx_last_q     <= 1'b0;
            tx_byte_cnt_q <= '0;
`endif
        end else if (fire) begin
            tx_data_q  <= acc_q[ACC_W-1 -: OUT_W];
            tx_valid_q <= 1'b1;
`ifdef GB_FLUSH_EN
            tx_last_q     <= flush_fire;
            tx_byte_cnt_q <= ($clog2(OUT_BYTES)+1)'(emit);
`endif
        end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

`ifdef GB_FLUSH_EN
    assign tx_last     = tx_last_q;
    assign tx_byte_cnt = tx_byte_cnt_q;
`endif

endmodule
